control: RTL and testbench
==========================

# control

Combinational instruction decoder and hazard/forwarding selector for the MIPS150 datapath. It decodes the current instruction (`Address`), compares it against the previous instruction (`OldAddress`) to generate ALU-operand forwarding selects, and produces the PC, register-file, ALU, memory and UART controls. It sits between instruction fetch and the execute stage. A single flag register marks `OldAddress` invalid after reset.

## Interface
- No parameters.
- `Clock`: input, 1 bit. System clock, rising edge.
- `Reset`: input, 1 bit. Asynchronous, active-low. Clears the previous-instruction-valid flag.
- `Address`: input, 32 bits. Current instruction word.
- `OldAddress`: input, 32 bits. Previous instruction word.
- `branch`: input, 1 bit. Branch-condition result for the current instruction.
- `RegWrite`: output, 1 bit. Register-file write enable.
- `RegDst`: output, 2 bits. Write register: 0 = rt, 1 = rd, 2 = $31.
- `PCsel`: output, 2 bits. Next PC: 0 = rs (JR/JALR), 1 = PC+4, 2 = branch target, 3 = jump target.
- `AluSelA`: output, 2 bits. ALU A operand: 0 = PC, 1 = rs, 2 = forwarded ALU result, 3 = shamt.
- `AluSelB`: output, 2 bits. ALU B operand: 0 = constant 8, 1 = rt, 2 = forwarded ALU result, 3 = extended immediate.
- `ALUop`: output, 4 bits. ALU operation, using the ALUop.vh codes.
- `ByteSel`: output, 4 bits. Memory access format:
  - [1:0] size: 0 = byte, 1 = half, 2 = word.
  - [2] unsigned load.
  - [3] store.
- `WEIM`: output, 1 bit. Instruction-memory write enable.
- `WEDM`: output, 1 bit. Data-memory write enable.
- `REUART`: output, 1 bit. UART RX-data read strobe.
- `WEUART`: output, 1 bit. UART TX-data write strobe.
- `UARTsel`: output, 2 bits. UART register: 0 = none, 1 = control (0x80000000), 2 = RX (0x80000004), 3 = TX (0x80000008).
- `RDsel`: output, 2 bits. Write-back source: 0 = ALU, 1 = UART read data, 2 = data memory.

## Operation
- **Decode.** All outputs decode combinationally from `Address`.
  - Defaults: `RegWrite`=0, `RegDst`=0, `PCsel`=1, `AluSelA`=1, `AluSelB`=1, `ByteSel`=0, all enables 0, `UARTsel`=0, `RDsel`=0.
- **R-type ALU ops:** `RegDst`=1, `RegWrite`=1.
  - SLL/SRL/SRA: `AluSelA`=3.
- **JR:** `PCsel`=0, `RegWrite`=0.
- **JALR:**
  - `PCsel`=0, `RegDst`=1, `RegWrite`=1.
  - ALU computes PC+8: `AluSelA`=0, `AluSelB`=0.
- **J / JAL:** `PCsel`=3.
  - JAL also: `RegDst`=2, `RegWrite`=1, `AluSelA`=0, `AluSelB`=0.
- **Branches:** `PCsel`=2 when `branch`=1, else 1; `RegWrite`=0.
- **I-type ALU and LUI:** `AluSelB`=3, `RegDst`=0, `RegWrite`=1.
- **Loads:** `AluSelB`=3, `RDsel`=2, `RegWrite`=1, `ByteSel` per opcode.
- **Stores:** `AluSelB`=3, `WEDM`=1, `WEIM`=1, `ByteSel[3]`=1. Downstream address logic gates the enables.
- **$0 destination:** `RegWrite` is forced to 0 when the selected destination register is $0.
- **UART map.** These three exact words are treated as UART accesses, overriding opcode decode:
  - 0x80000008: `WEUART`=1, `UARTsel`=3.
  - 0x80000004: `REUART`=1, `UARTsel`=2, `RDsel`=1.
  - 0x80000000: `UARTsel`=1, `RDsel`=1.
  - These encodings are LB to $0, which are architectural no-ops, so the override loses nothing.
- **Forwarding.** The previous instruction "produces" when all of these hold:
  - `valid_q`=1;
  - its decoded `RegWrite`=1;
  - it is not a load;
  - its destination register is nonzero.
- When it produces:
  - `AluSelA`=2 if the current `AluSelA` would be 1 and rs equals the previous destination.
  - `AluSelB`=2 if the current `AluSelB` would be 1 and rt equals the previous destination.
  - PC, shamt, constant-8 and immediate operands are never forwarded.

## Timing
- All outputs are combinational, zero-cycle latency from `Address`, `OldAddress` and `branch`.
- `valid_q` behaviour:
  - Reset to 0 asynchronously when `Reset`=0.
  - Set to 1 on the first rising `Clock` edge after reset release.
  - While 0, `OldAddress` is treated as a nop and no forwarding occurs.
- There is no other state, so outputs have no reset value beyond the decode of their inputs.

## Configuration
- `CONTROL_FORWARDING_EN` defined: forwarding selects (value 2) are generated as described.
- Not defined: `AluSelA` and `AluSelB` never equal 2. Hazards are resolved by software scheduling.

## Test plan
- ADD $s0,$s0,$s0 with previous = nop → `RegWrite`=1, `RegDst`=1, `PCsel`=1, `AluSelA`=1, `AluSelB`=1.
- ADD $s0,$s0,$s0 after ADD $s0,$s0,$s0 (forwarding enabled, `valid_q`=1) → `AluSelA`=2, `AluSelB`=2.
- JALR $s1,$s0 after ADD $s0 → `AluSelA`=0, `AluSelB`=0, `RegDst`=1, `PCsel`=0.
- LW $s0,0($s0) → `RDsel`=2, `ByteSel`=4'b0010, `RegWrite`=1.
- Address 0x80000008 → `WEUART`=1, `REUART`=0, `UARTsel`=3.
- BEQ with `branch`=1 then `branch`=0 → `PCsel`=2, then 1. Separately, assert `Reset` low and repeat the back-to-back ADD pair → no forwarding until the first clock edge after release.

Source files
------------

// File: rtl/control_if.sv
// rtl/control_if.sv - instruction words in, datapath controls out, for the MIPS150 decoder
interface control_if;
  logic [31:0] Address;
  logic [31:0] OldAddress;
  logic        branch;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  PCsel;
  logic [1:0]  AluSelA;
  logic [1:0]  AluSelB;
  logic [3:0]  ALUop;
  logic [3:0]  ByteSel;
  logic        WEIM;
  logic        WEDM;
  logic        REUART;
  logic        WEUART;
  logic [1:0]  UARTsel;
  logic [1:0]  RDsel;

  modport master (
    output Address, OldAddress, branch,
    input  RegWrite, RegDst, PCsel, AluSelA, AluSelB, ALUop, ByteSel,
    input  WEIM, WEDM, REUART, WEUART, UARTsel, RDsel
  );

  modport slave (
    input  Address, OldAddress, branch,
    output RegWrite, RegDst, PCsel, AluSelA, AluSelB, ALUop, ByteSel,
    output WEIM, WEDM, REUART, WEUART, UARTsel, RDsel
  );
endinterface

// File: rtl/control.sv
// rtl/control.sv - MIPS150 decoder and ALU-operand forwarding selector
// Forwarding selects are generated only when CONTROL_FORWARDING_EN is defined.
module control (
  input  logic     Clock,
  input  logic     Reset,
  control_if.slave bus
);
  localparam logic [3:0] ALU_ADDU = 4'd0,  ALU_SUBU = 4'd1,  ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3,  ALU_AND  = 4'd4,  ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6,  ALU_LUI  = 4'd7,  ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_NOR  = 4'd11;

  localparam logic [31:0] UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] UART_RX   = 32'h8000_0004;
  localparam logic [31:0] UART_TX   = 32'h8000_0008;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] pc_sel;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [3:0] alu_op;
    logic [3:0] byte_sel;
    logic       we_im;
    logic       we_dm;
    logic       re_uart;
    logic       we_uart;
    logic [1:0] uart_sel;
    logic [1:0] rd_sel;
    logic       is_load;
    logic [4:0] dest;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins, input logic br);
    dec_t d;
    d        = '0;
    d.pc_sel = 2'd1;
    d.sel_a  = 2'd1;
    d.sel_b  = 2'd1;
    // The UART words are LB-to-$0 encodings, so claiming them loses no instruction.
    if (ins == UART_TX) begin
      d.we_uart = 1'b1; d.uart_sel = 2'd3;
    end else if (ins == UART_RX) begin
      d.re_uart = 1'b1; d.uart_sel = 2'd2; d.rd_sel = 2'd1;
    end else if (ins == UART_CTRL) begin
      d.uart_sel = 2'd1; d.rd_sel = 2'd1;
    end else begin
      case (ins[31:26])
        6'h00: begin
          d.reg_dst   = 2'd1;
          d.reg_write = 1'b1;
          case (ins[5:0])
            6'h00: begin d.sel_a = 2'd3; d.alu_op = ALU_SLL; end
            6'h02: begin d.sel_a = 2'd3; d.alu_op = ALU_SRL; end
            6'h03: begin d.sel_a = 2'd3; d.alu_op = ALU_SRA; end
            6'h04: d.alu_op = ALU_SLL;
            6'h06: d.alu_op = ALU_SRL;
            6'h07: d.alu_op = ALU_SRA;
            6'h08: begin d.pc_sel = 2'd0; d.reg_write = 1'b0; d.reg_dst = 2'd0; end
            6'h09: begin d.pc_sel = 2'd0; d.sel_a = 2'd0; d.sel_b = 2'd0; end
            6'h20, 6'h21: d.alu_op = ALU_ADDU;
            6'h22, 6'h23: d.alu_op = ALU_SUBU;
            6'h24: d.alu_op = ALU_AND;
            6'h25: d.alu_op = ALU_OR;
            6'h26: d.alu_op = ALU_XOR;
            6'h27: d.alu_op = ALU_NOR;
            6'h2a: d.alu_op = ALU_SLT;
            6'h2b: d.alu_op = ALU_SLTU;
            default: begin d.reg_dst = 2'd0; d.reg_write = 1'b0; end
          endcase
        end
        6'h02: d.pc_sel = 2'd3;
        6'h03: begin
          d.pc_sel = 2'd3; d.reg_dst = 2'd2; d.reg_write = 1'b1;
          d.sel_a  = 2'd0; d.sel_b   = 2'd0;
        end
        6'h01, 6'h04, 6'h05, 6'h06, 6'h07: d.pc_sel = br ? 2'd2 : 2'd1;
        6'h08, 6'h09: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_ADDU; end
        6'h0a: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_SLT;  end
        6'h0b: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_SLTU; end
        6'h0c: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_AND;  end
        6'h0d: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_OR;   end
        6'h0e: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_XOR;  end
        6'h0f: begin d.sel_b = 2'd3; d.reg_write = 1'b1; d.alu_op = ALU_LUI;  end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
          d.sel_b    = 2'd3; d.rd_sel = 2'd2; d.reg_write = 1'b1; d.is_load = 1'b1;
          d.byte_sel = {1'b0, ins[28], ins[27:26] == 2'b11 ? 2'd2 : {1'b0, ins[26]}};
        end
        6'h28, 6'h29, 6'h2b: begin
          d.sel_b    = 2'd3; d.we_dm = 1'b1; d.we_im = 1'b1;
          d.byte_sel = {2'b10, ins[27:26] == 2'b11 ? 2'd2 : {1'b0, ins[26]}};
        end
        default: ;
      endcase
    end
    case (d.reg_dst)
      2'd0:    d.dest = ins[20:16];
      2'd1:    d.dest = ins[15:11];
      default: d.dest = 5'd31;
    endcase
    if (d.dest == 5'd0) d.reg_write = 1'b0;
    return d;
  endfunction

  logic valid_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) valid_q <= 1'b0;
    else        valid_q <= 1'b1;
  end

  dec_t       cur;
  dec_t       prv;
  logic       produces;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       unused_ok;

  always_comb begin
    cur      = decode(bus.Address, bus.branch);
    prv      = decode(bus.OldAddress, 1'b0);
    // Load data is not ready in time to forward; those hazards stay with software.
    produces = valid_q && prv.reg_write && !prv.is_load && (prv.dest != 5'd0);
    sel_a    = cur.sel_a;
    sel_b    = cur.sel_b;
`ifdef CONTROL_FORWARDING_EN
    if (produces && cur.sel_a == 2'd1 && bus.Address[25:21] == prv.dest) sel_a = 2'd2;
    if (produces && cur.sel_b == 2'd1 && bus.Address[20:16] == prv.dest) sel_b = 2'd2;
`endif
  end

  assign unused_ok = ^{cur.is_load, cur.dest, prv, produces};

  assign bus.RegWrite = cur.reg_write;
  assign bus.RegDst   = cur.reg_dst;
  assign bus.PCsel    = cur.pc_sel;
  assign bus.AluSelA  = sel_a;
  assign bus.AluSelB  = sel_b;
  assign bus.ALUop    = cur.alu_op;
  assign bus.ByteSel  = cur.byte_sel;
  assign bus.WEIM     = cur.we_im;
  assign bus.WEDM     = cur.we_dm;
  assign bus.REUART   = cur.re_uart;
  assign bus.WEUART   = cur.we_uart;
  assign bus.UARTsel  = cur.uart_sel;
  assign bus.RDsel    = cur.rd_sel;
endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - random and directed decoder checks against a mnemonic-level model
module tb_control;
`ifdef CONTROL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int C_SHIFT = 0, C_RALU = 1, C_JR = 2, C_JALR = 3, C_J = 4, C_JAL = 5;
  localparam int C_BR = 6, C_IALU = 7, C_LOAD = 8, C_STORE = 9, C_UART = 10;
  localparam int NKIND = 41;
  localparam int K_NOP = 0, K_JALR = 7, K_ADD = 16, K_BEQ = 19, K_LW = 32, K_UTX = 38;

  localparam logic [31:0] W_ADD   = 32'h0210_8020;
  localparam logic [31:0] W_ADD0  = 32'h0210_0020;
  localparam logic [31:0] W_ADDZ  = 32'h0000_8020;
  localparam logic [31:0] W_JALR  = 32'h0200_8809;
  localparam logic [31:0] W_LW    = 32'h8E10_0000;
  localparam logic [31:0] W_BEQ   = 32'h1211_0004;

  logic Clock = 1'b0;
  logic Reset;
  control_if bus ();
  control dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  bit exp_valid;

  typedef struct packed {
    logic       rw;
    logic [1:0] dst, pc, sa, sb;
    logic [3:0] alu, bs;
    logic       weim, wedm, reu, weu;
    logic [1:0] us, rds;
    logic       alu_chk, load;
    logic [4:0] dest;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Mnemonic table: class, opcode-or-funct, ALU operation, memory format.
  function automatic void kind_info(input int k, output int cls, output logic [5:0] code,
                                    output logic [3:0] alu, output logic [3:0] bs);
    cls = C_UART; code = 6'h00; alu = 4'd0; bs = 4'd0;
    case (k)
      0:  begin cls = C_SHIFT; code = 6'h00; alu = 4'd8;  end
      1:  begin cls = C_SHIFT; code = 6'h02; alu = 4'd9;  end
      2:  begin cls = C_SHIFT; code = 6'h03; alu = 4'd10; end
      3:  begin cls = C_RALU;  code = 6'h04; alu = 4'd8;  end
      4:  begin cls = C_RALU;  code = 6'h06; alu = 4'd9;  end
      5:  begin cls = C_RALU;  code = 6'h07; alu = 4'd10; end
      6:  begin cls = C_JR;    code = 6'h08; end
      7:  begin cls = C_JALR;  code = 6'h09; alu = 4'd0;  end
      8:  begin cls = C_RALU;  code = 6'h21; alu = 4'd0;  end
      9:  begin cls = C_RALU;  code = 6'h23; alu = 4'd1;  end
      10: begin cls = C_RALU;  code = 6'h24; alu = 4'd4;  end
      11: begin cls = C_RALU;  code = 6'h25; alu = 4'd5;  end
      12: begin cls = C_RALU;  code = 6'h26; alu = 4'd6;  end
      13: begin cls = C_RALU;  code = 6'h27; alu = 4'd11; end
      14: begin cls = C_RALU;  code = 6'h2a; alu = 4'd2;  end
      15: begin cls = C_RALU;  code = 6'h2b; alu = 4'd3;  end
      16: begin cls = C_RALU;  code = 6'h20; alu = 4'd0;  end
      17: begin cls = C_J;     code = 6'h02; end
      18: begin cls = C_JAL;   code = 6'h03; alu = 4'd0;  end
      19: begin cls = C_BR;    code = 6'h04; end
      20: begin cls = C_BR;    code = 6'h05; end
      21: begin cls = C_BR;    code = 6'h06; end
      22: begin cls = C_BR;    code = 6'h07; end
      23: begin cls = C_IALU;  code = 6'h09; alu = 4'd0;  end
      24: begin cls = C_IALU;  code = 6'h0a; alu = 4'd2;  end
      25: begin cls = C_IALU;  code = 6'h0b; alu = 4'd3;  end
      26: begin cls = C_IALU;  code = 6'h0c; alu = 4'd4;  end
      27: begin cls = C_IALU;  code = 6'h0d; alu = 4'd5;  end
      28: begin cls = C_IALU;  code = 6'h0e; alu = 4'd6;  end
      29: begin cls = C_IALU;  code = 6'h0f; alu = 4'd7;  end
      30: begin cls = C_LOAD;  code = 6'h20; bs = 4'b0000; end
      31: begin cls = C_LOAD;  code = 6'h21; bs = 4'b0001; end
      32: begin cls = C_LOAD;  code = 6'h23; bs = 4'b0010; end
      33: begin cls = C_LOAD;  code = 6'h24; bs = 4'b0100; end
      34: begin cls = C_LOAD;  code = 6'h25; bs = 4'b0101; end
      35: begin cls = C_STORE; code = 6'h28; bs = 4'b1000; end
      36: begin cls = C_STORE; code = 6'h29; bs = 4'b1001; end
      37: begin cls = C_STORE; code = 6'h2b; bs = 4'b1010; end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] encode(input int k);
    int cls;
    logic [5:0] code;
    logic [3:0] unused_alu, unused_bs;
    logic [4:0] rs, rt, rd;
    kind_info(k, cls, code, unused_alu, unused_bs);
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    if (k == 30 && rs == 5'd0 && rt == 5'd0) rt = 5'd1;
    case (cls)
      C_SHIFT, C_RALU, C_JR, C_JALR: return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), code};
      C_J, C_JAL: return {code, 26'($urandom)};
      C_UART: return (k == 38) ? 32'h8000_0008 : (k == 39) ? 32'h8000_0004 : 32'h8000_0000;
      default: return {code, rs, rt, 16'($urandom)};
    endcase
  endfunction

  function automatic exp_t model(input int k, input logic [31:0] w, input logic br);
    exp_t e;
    int cls;
    logic [5:0] unused_code;
    logic [3:0] alu, bs;
    kind_info(k, cls, unused_code, alu, bs);
    e = '0; e.pc = 2'd1; e.sa = 2'd1; e.sb = 2'd1; e.alu = alu;
    case (cls)
      C_SHIFT: begin e.rw = 1'b1; e.dst = 2'd1; e.sa = 2'd3; e.dest = w[15:11]; e.alu_chk = 1'b1; end
      C_RALU:  begin e.rw = 1'b1; e.dst = 2'd1; e.dest = w[15:11]; e.alu_chk = 1'b1; end
      C_JR:    e.pc = 2'd0;
      C_JALR:  begin
        e.pc = 2'd0; e.dst = 2'd1; e.rw = 1'b1; e.sa = 2'd0; e.sb = 2'd0;
        e.dest = w[15:11]; e.alu_chk = 1'b1;
      end
      C_J:     e.pc = 2'd3;
      C_JAL:   begin
        e.pc = 2'd3; e.dst = 2'd2; e.rw = 1'b1; e.sa = 2'd0; e.sb = 2'd0;
        e.dest = 5'd31; e.alu_chk = 1'b1;
      end
      C_BR:    e.pc = br ? 2'd2 : 2'd1;
      C_IALU:  begin e.sb = 2'd3; e.rw = 1'b1; e.dest = w[20:16]; e.alu_chk = 1'b1; end
      C_LOAD:  begin
        e.sb = 2'd3; e.rds = 2'd2; e.rw = 1'b1; e.bs = bs; e.load = 1'b1;
        e.dest = w[20:16]; e.alu_chk = 1'b1;
      end
      C_STORE: begin e.sb = 2'd3; e.wedm = 1'b1; e.weim = 1'b1; e.bs = bs; e.alu_chk = 1'b1; end
      default: begin
        if (w[3:0] == 4'h8)      begin e.weu = 1'b1; e.us = 2'd3; end
        else if (w[3:0] == 4'h4) begin e.reu = 1'b1; e.us = 2'd2; e.rds = 2'd1; end
        else                     begin e.us = 2'd1; e.rds = 2'd1; end
      end
    endcase
    if (e.dest == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  task automatic run_vec(input int k, input logic [31:0] w, input int pk, input logic [31:0] pw,
                         input logic br);
    exp_t e, p;
    string s;
    bus.Address = w; bus.OldAddress = pw; bus.branch = br;
    e = model(k, w, br);
    p = model(pk, pw, 1'b0);
    if (FWD && exp_valid && p.rw && !p.load && p.dest != 5'd0) begin
      if (e.sa == 2'd1 && w[25:21] == p.dest) e.sa = 2'd2;
      if (e.sb == 2'd1 && w[20:16] == p.dest) e.sb = 2'd2;
    end
    #1;
    s = $sformatf(" k%0d w%08h old%08h", k, w, pw);
    check({"RegWrite", s}, 32'(bus.RegWrite), 32'(e.rw));
    check({"RegDst", s},   32'(bus.RegDst),   32'(e.dst));
    check({"PCsel", s},    32'(bus.PCsel),    32'(e.pc));
    check({"AluSelA", s},  32'(bus.AluSelA),  32'(e.sa));
    check({"AluSelB", s},  32'(bus.AluSelB),  32'(e.sb));
    check({"ByteSel", s},  32'(bus.ByteSel),  32'(e.bs));
    check({"mem_uart", s},
          32'({bus.WEIM, bus.WEDM, bus.REUART, bus.WEUART, bus.UARTsel, bus.RDsel}),
          32'({e.weim, e.wedm, e.reu, e.weu, e.us, e.rds}));
    if (e.alu_chk) check({"ALUop", s}, 32'(bus.ALUop), 32'(e.alu));
  endtask

  task automatic step();
    @(negedge Clock);
    if (Reset) exp_valid = 1'b1;
  endtask

  int k, pk;
  logic [31:0] w, pw;

  initial begin
    Reset = 1'b0; exp_valid = 1'b0;
    bus.Address = 32'h0; bus.OldAddress = 32'h0; bus.branch = 1'b0;
    step();
    run_vec(K_ADD, W_ADD, K_ADD, W_ADD, 1'b0);
    check("rst_hold_sel_a", 32'(bus.AluSelA), 32'd1);
    Reset = 1'b1;
    run_vec(K_ADD, W_ADD, K_ADD, W_ADD, 1'b0);
    check("rst_release_sel_b", 32'(bus.AluSelB), 32'd1);
    step();
    run_vec(K_ADD, W_ADD, K_ADD, W_ADD, 1'b0);
    check("fwd_sel_a", 32'(bus.AluSelA), FWD ? 32'd2 : 32'd1);
    check("fwd_sel_b", 32'(bus.AluSelB), FWD ? 32'd2 : 32'd1);
    run_vec(K_ADD, W_ADD, K_NOP, 32'h0, 1'b0);
    check("add_nop", 32'({bus.RegWrite, bus.RegDst, bus.PCsel, bus.AluSelA, bus.AluSelB}),
          32'({1'b1, 2'd1, 2'd1, 2'd1, 2'd1}));
    run_vec(K_JALR, W_JALR, K_ADD, W_ADD, 1'b0);
    check("jalr", 32'({bus.AluSelA, bus.AluSelB, bus.RegDst, bus.PCsel}),
          32'({2'd0, 2'd0, 2'd1, 2'd0}));
    step();
    run_vec(K_LW, W_LW, K_NOP, 32'h0, 1'b0);
    check("lw", 32'({bus.RDsel, bus.ByteSel, bus.RegWrite}), 32'({2'd2, 4'b0010, 1'b1}));
    run_vec(K_UTX, 32'h8000_0008, K_NOP, 32'h0, 1'b0);
    check("uart_tx", 32'({bus.WEUART, bus.REUART, bus.UARTsel}), 32'({1'b1, 1'b0, 2'd3}));
    run_vec(K_BEQ, W_BEQ, K_NOP, 32'h0, 1'b1);
    check("beq_taken", 32'(bus.PCsel), 32'd2);
    run_vec(K_BEQ, W_BEQ, K_NOP, 32'h0, 1'b0);
    check("beq_not_taken", 32'(bus.PCsel), 32'd1);
    step();
    run_vec(K_ADD, W_ADD, K_LW, W_LW, 1'b0);
    check("no_fwd_after_load", 32'({bus.AluSelA, bus.AluSelB}), 32'({2'd1, 2'd1}));
    run_vec(K_ADD, W_ADDZ, K_ADD, W_ADD0, 1'b0);
    check("no_fwd_from_r0", 32'({bus.AluSelA, bus.AluSelB, bus.RegWrite}),
          32'({2'd1, 2'd1, 1'b1}));

    pk = K_NOP; pw = 32'h0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (i == 300) begin Reset = 1'b0; exp_valid = 1'b0; end
      if (i == 304) Reset = 1'b1;
      k = $urandom_range(0, NKIND - 1);
      w = encode(k);
      run_vec(k, w, pk, pw, 1'($urandom_range(0, 1)));
      pk = k; pw = w;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
